motoro_nphase_commutator: RTL and testbench



---
 rtl/motoro_nphase_commutator.sv | 188 ++++++++++++++++++
 tb/tb_motoro_nphase_commutator.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/motoro_nphase_commutator.sv
// N-phase 180-degree block commutation generator.
// Drives complementary high/low gate enables for PHASES half-bridges over
// 2*PHASES electrical sectors, with per-phase dead time on every level
// change, a saturating step-period register, direction reversal at sector
// boundaries and force-stop. All outputs come straight from flops.
module motoro_nphase_commutator #(
  parameter int PHASES    = 3,
  parameter int PER_W     = 16,
  parameter int PER_INIT  = 1000,
  parameter int PER_MIN   = 50,
  parameter int PER_MAX   = 60000,
  parameter int PER_DELTA = 10,
  parameter int DEAD_CYC  = 4,
  localparam int SEC_W    = $clog2(2 * PHASES)
) (
  input  logic              clkI,
  input  logic              rstI,
  input  logic              startI,
  input  logic              forceStopI,
  input  logic              invRotateI,
  input  logic              freqIncI,
  input  logic              freqDecI,
  output logic [PHASES-1:0] hpO,
  output logic [PHASES-1:0] lnO,
  output logic              runO,
  output logic [SEC_W-1:0]  sectorO,
  output logic [PER_W-1:0]  periodO
);

  localparam int S  = 2 * PHASES;
  localparam int DW = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;

  localparam logic [PER_W:0]   DELTA_X = (PER_W + 1)'(PER_DELTA);
  localparam logic [PER_W:0]   MIN_X   = (PER_W + 1)'(PER_MIN);
  localparam logic [PER_W:0]   MAX_X   = (PER_W + 1)'(PER_MAX);
  localparam logic [PER_W-1:0] INIT_P  = PER_W'(PER_INIT);
  localparam logic [DW-1:0]    DEAD_LD = DW'(DEAD_CYC);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                     state_q, state_d;
  logic [PER_W-1:0]           cnt_q, cnt_d;
  logic [SEC_W-1:0]           sec_q, sec_d;
  logic [PER_W-1:0]           per_next_q, per_next_d;
  logic [PER_W-1:0]           per_act_q, per_act_d;
  logic [PHASES-1:0]          lvl_q, lvl_d;
  logic [PHASES-1:0]          en_q, en_d;
  logic [PHASES-1:0][DW-1:0]  dead_q, dead_d;
  logic [PHASES-1:0]          hp_q, hp_d;
  logic [PHASES-1:0]          ln_q, ln_d;

  logic [PER_W:0]             inc_tmp_s;
  logic [PER_W:0]             dec_tmp_s;
  logic                       boundary_s;
  logic [PHASES-1:0]          desired_s;

  // Phase p is high when (sector - 2p) mod S falls in the first half-turn.
  function automatic logic [PHASES-1:0] desired_f(input logic [SEC_W-1:0] sec);
    logic [SEC_W:0] off;
    desired_f = '0;
    for (int p = 0; p < PHASES; p++) begin
      off = {1'b0, sec} + (SEC_W + 1)'(S) - (SEC_W + 1)'(2 * p);
      if (off >= (SEC_W + 1)'(S)) off = off - (SEC_W + 1)'(S);
      else                        off = off;
      desired_f[p] = (off < (SEC_W + 1)'(PHASES));
    end
  endfunction

  // Saturating period register; simultaneous inc and dec cancel out.
  always_comb begin
    inc_tmp_s  = {1'b0, per_next_q} - DELTA_X;
    dec_tmp_s  = {1'b0, per_next_q} + DELTA_X;
    per_next_d = per_next_q;
    if (freqIncI && !freqDecI) begin
      if (inc_tmp_s[PER_W] || (inc_tmp_s < MIN_X)) per_next_d = MIN_X[PER_W-1:0];
      else                                         per_next_d = inc_tmp_s[PER_W-1:0];
    end else if (freqDecI && !freqIncI) begin
      if (dec_tmp_s > MAX_X) per_next_d = MAX_X[PER_W-1:0];
      else                   per_next_d = dec_tmp_s[PER_W-1:0];
    end else begin
      per_next_d = per_next_q;
    end
  end

  // State machine, period counter and sector sequencing.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sec_d      = sec_q;
    per_act_d  = per_act_q;
    boundary_s = (cnt_q == (per_act_q - PER_W'(1)));
    case (state_q)
      IDLE: begin
        if (startI && !forceStopI) begin
          state_d   = RUN;
          cnt_d     = '0;
          sec_d     = '0;
          per_act_d = per_next_q;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (forceStopI) begin
          state_d = IDLE;
          cnt_d   = '0;
          sec_d   = '0;
        end else if (boundary_s) begin
          cnt_d     = '0;
          per_act_d = per_next_q;
          if (invRotateI) sec_d = (sec_q == '0) ? SEC_W'(S - 1) : sec_q - SEC_W'(1);
          else            sec_d = (sec_q == SEC_W'(S - 1)) ? '0 : sec_q + SEC_W'(1);
        end else begin
          cnt_d = cnt_q + PER_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        sec_d   = '0;
      end
    endcase
  end

  // Per-phase dead time: any change of wanted level darkens both sides first.
  // Evaluated on next-state values so the gate enables can be registered.
  always_comb begin
    desired_s = desired_f(sec_d);
    lvl_d     = lvl_q;
    en_d      = en_q;
    dead_d    = dead_q;
    hp_d      = '0;
    ln_d      = '0;
    if (state_d == RUN) begin
      for (int p = 0; p < PHASES; p++) begin
        if (!en_q[p] || (desired_s[p] != lvl_q[p])) begin
          lvl_d[p]  = desired_s[p];
          en_d[p]   = 1'b1;
          dead_d[p] = DEAD_LD;
        end else if (dead_q[p] != '0) begin
          dead_d[p] = dead_q[p] - DW'(1);
        end else begin
          dead_d[p] = '0;
        end
        hp_d[p] = (dead_d[p] == '0) &  lvl_d[p];
        ln_d[p] = (dead_d[p] == '0) & ~lvl_d[p];
      end
    end else begin
      lvl_d  = '0;
      en_d   = '0;
      dead_d = '0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clkI) begin
    if (rstI) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sec_q      <= '0;
      per_next_q <= INIT_P;
      per_act_q  <= INIT_P;
      lvl_q      <= '0;
      en_q       <= '0;
      dead_q     <= '0;
      hp_q       <= '0;
      ln_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sec_q      <= sec_d;
      per_next_q <= per_next_d;
      per_act_q  <= per_act_d;
      lvl_q      <= lvl_d;
      en_q       <= en_d;
      dead_q     <= dead_d;
      hp_q       <= hp_d;
      ln_q       <= ln_d;
    end
  end

  assign hpO     = hp_q;
  assign lnO     = ln_q;
  assign runO    = (state_q == RUN);
  assign sectorO = sec_q;
  assign periodO = per_act_q;

endmodule

// File: tb/tb_motoro_nphase_commutator.sv
// Directed bench for motoro_nphase_commutator, PHASES=3, DEAD_CYC=4, PER_INIT=100.
module tb_motoro_nphase_commutator;

  logic        clkI = 1'b0;
  logic        rstI, startI, forceStopI, invRotateI, freqIncI, freqDecI;
  logic [2:0]  hpO, lnO;
  logic        runO;
  logic [2:0]  sectorO;
  logic [15:0] periodO;

  int checks   = 0;
  int failures = 0;

  motoro_nphase_commutator #(
    .PHASES(3), .PER_W(16), .PER_INIT(100), .PER_MIN(50),
    .PER_MAX(60000), .PER_DELTA(10), .DEAD_CYC(4)
  ) dut (
    .clkI(clkI), .rstI(rstI), .startI(startI), .forceStopI(forceStopI),
    .invRotateI(invRotateI), .freqIncI(freqIncI), .freqDecI(freqDecI),
    .hpO(hpO), .lnO(lnO), .runO(runO), .sectorO(sectorO), .periodO(periodO)
  );

  always #5 clkI = ~clkI;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle and sample 1 ns after the edge; shoot-through checked every cycle.
  task automatic tick;
    @(posedge clkI);
    #1;
    check_eq("no_overlap", 32'(hpO & lnO), 32'd0);
  endtask

  // Called on the first cycle of a sector; leaves on the first cycle of the next.
  task automatic run_sector(input logic [2:0] esec, input logic [2:0] ehp,
                            input logic [2:0] php, input int len);
    logic [2:0] dhp, dln, eln;
    dhp = php & ehp;
    dln = ~php & ~ehp;
    eln = ~ehp;
    check_eq("sector", 32'(sectorO), 32'(esec));
    check_eq("hp_dead_first", 32'(hpO), 32'(dhp));
    check_eq("ln_dead_first", 32'(lnO), 32'(dln));
    repeat (3) tick;
    check_eq("hp_dead_last", 32'(hpO), 32'(dhp));
    check_eq("ln_dead_last", 32'(lnO), 32'(dln));
    tick;
    check_eq("hp_driven", 32'(hpO), 32'(ehp));
    check_eq("ln_driven", 32'(lnO), 32'(eln));
    repeat (len - 4) tick;
  endtask

  initial begin
    rstI = 1'b1; startI = 1'b0; forceStopI = 1'b0;
    invRotateI = 1'b0; freqIncI = 1'b0; freqDecI = 1'b0;
    repeat (3) tick;
    check_eq("rst_hp", 32'(hpO), 32'd0);
    check_eq("rst_ln", 32'(lnO), 32'd0);
    check_eq("rst_run", 32'(runO), 32'd0);
    check_eq("rst_sector", 32'(sectorO), 32'd0);
    check_eq("rst_period", 32'(periodO), 32'd100);
    rstI = 1'b0;
    tick;

    // start together with stop in IDLE: stop wins
    startI = 1'b1; forceStopI = 1'b1;
    tick;
    startI = 1'b0; forceStopI = 1'b0;
    check_eq("idle_stop_wins_run", 32'(runO), 32'd0);
    check_eq("idle_stop_wins_hp", 32'(hpO), 32'd0);
    tick;

    // start: RUN next cycle, sector 0 gates after 4 dark cycles
    startI = 1'b1;
    tick;
    startI = 1'b0;
    check_eq("start_run", 32'(runO), 32'd1);
    check_eq("start_hp", 32'(hpO), 32'd0);
    check_eq("start_ln", 32'(lnO), 32'd0);
    check_eq("start_sector", 32'(sectorO), 32'd0);
    check_eq("start_period", 32'(periodO), 32'd100);
    repeat (3) tick;
    check_eq("s0_dark_hp", 32'(hpO), 32'd0);
    check_eq("s0_dark_ln", 32'(lnO), 32'd0);
    tick;
    check_eq("s0_hp", 32'(hpO), 32'b101);
    check_eq("s0_ln", 32'(lnO), 32'b010);
    repeat (96) tick;

    // forward rotation through one full turn
    run_sector(3'd1, 3'b001, 3'b101, 100);
    run_sector(3'd2, 3'b011, 3'b001, 100);
    run_sector(3'd3, 3'b010, 3'b011, 100);
    run_sector(3'd4, 3'b110, 3'b010, 100);
    run_sector(3'd5, 3'b100, 3'b110, 100);
    run_sector(3'd0, 3'b101, 3'b100, 100);

    // mid-sector reversal (and an ignored start) only acts at the boundary
    repeat (50) tick;
    invRotateI = 1'b1; startI = 1'b1;
    tick;
    startI = 1'b0;
    repeat (48) tick;
    check_eq("rev_pre_boundary", 32'(sectorO), 32'd1);
    tick;
    run_sector(3'd0, 3'b101, 3'b001, 100);
    run_sector(3'd5, 3'b100, 3'b101, 100);

    // ten inc pulses saturate at 50, then inc+dec together does nothing
    check_eq("s4_sector", 32'(sectorO), 32'd4);
    check_eq("s4_period", 32'(periodO), 32'd100);
    freqIncI = 1'b1;
    repeat (10) tick;
    freqDecI = 1'b1;
    tick;
    freqIncI = 1'b0; freqDecI = 1'b0;
    repeat (89) tick;
    check_eq("period_sat", 32'(periodO), 32'd50);
    run_sector(3'd3, 3'b010, 3'b110, 50);
    check_eq("s2_sector", 32'(sectorO), 32'd2);
    check_eq("s2_period", 32'(periodO), 32'd50);
    freqDecI = 1'b1;
    tick;
    freqIncI = 1'b1;
    tick;
    freqIncI = 1'b0; freqDecI = 1'b0;
    repeat (48) tick;
    check_eq("s1_sector", 32'(sectorO), 32'd1);
    check_eq("period_dec_both", 32'(periodO), 32'd60);

    // force stop in RUN
    repeat (10) tick;
    forceStopI = 1'b1;
    tick;
    forceStopI = 1'b0;
    check_eq("stop_hp", 32'(hpO), 32'd0);
    check_eq("stop_ln", 32'(lnO), 32'd0);
    check_eq("stop_run", 32'(runO), 32'd0);
    check_eq("stop_sector", 32'(sectorO), 32'd0);
    invRotateI = 1'b0;
    tick;

    // restart with period 60, then reset in the middle of a dead gap
    startI = 1'b1;
    tick;
    startI = 1'b0;
    check_eq("restart_period", 32'(periodO), 32'd60);
    repeat (4) tick;
    check_eq("restart_hp", 32'(hpO), 32'b101);
    repeat (56) tick;
    check_eq("restart_s1_sector", 32'(sectorO), 32'd1);
    check_eq("restart_s1_hp", 32'(hpO), 32'b001);
    check_eq("restart_s1_ln", 32'(lnO), 32'b010);
    tick;
    rstI = 1'b1;
    tick;
    rstI = 1'b0;
    check_eq("midrst_hp", 32'(hpO), 32'd0);
    check_eq("midrst_ln", 32'(lnO), 32'd0);
    check_eq("midrst_run", 32'(runO), 32'd0);
    check_eq("midrst_sector", 32'(sectorO), 32'd0);
    check_eq("midrst_period", 32'(periodO), 32'd100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
